// File: rtl/ldpc_fixed_pkg.sv
// rtl/ldpc_fixed_pkg.sv - shared fixed-point constants and state type for the VN datapath
package ldpc_fixed_pkg;

  // Default word geometry: 8 integer bits, 8 fraction bits
  localparam int DEF_INT  = 8;
  localparam int DEF_FRAC = 8;
  localparam int DEF_W    = DEF_INT + DEF_FRAC;

  // Saturation rails at the default width
  localparam logic [DEF_W-1:0] MAX_POS = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic [DEF_W-1:0] MAX_NEG = {1'b1, {(DEF_W-1){1'b0}}};

  // Variable-node frame state
  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } vn_state_e;

endpackage

// File: rtl/sat_subtractor.sv
// rtl/sat_subtractor.sv - combinational saturating two's-complement subtractor c = sat(a - b)
module sat_subtractor
  import ldpc_fixed_pkg::*;
#(
  parameter int INT  = DEF_INT,
  parameter int FRAC = DEF_FRAC
) (
  input  logic [INT+FRAC-1:0] a,
  input  logic [INT+FRAC-1:0] b,
  output logic [INT+FRAC-1:0] c
);

  localparam int W = INT + FRAC;
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] diff;

  // Wrap-around difference, clamped toward the sign of a when the sign flips unexpectedly
  always_comb begin
    diff = a - b;
    c    = diff;
    if ((a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])) begin
      c = a[W-1] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/vn_extrinsic_sub.sv
// rtl/vn_extrinsic_sub.sv - LDPC variable-node extrinsic message generator (optional VN_HARD_DECISION_EN adds out_hard)
module vn_extrinsic_sub
  import ldpc_fixed_pkg::*;
#(
  parameter int INT  = DEF_INT,
  parameter int FRAC = DEF_FRAC,
  parameter int DEG  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INT+FRAC-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INT+FRAC-1:0] out_data,
  output logic                out_last
`ifdef VN_HARD_DECISION_EN
  ,
  output logic                out_hard
`endif
);

  localparam int W  = INT + FRAC;
  localparam int CW = $clog2(DEG + 1);
  localparam int KW = $clog2(DEG);
  localparam logic [W-1:0]  SAT_POS  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  SAT_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DEG);
  localparam logic [KW-1:0] K_LAST   = KW'(DEG - 1);

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] s;
    s = x + y;
    if ((x[W-1] == y[W-1]) && (s[W-1] != x[W-1])) begin
      s = x[W-1] ? SAT_NEG : SAT_POS;
    end
    return s;
  endfunction

  vn_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [KW-1:0] k_q;
  logic [W-1:0]  total_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic [W-1:0]  msg_q [DEG];

  logic          in_fire;
  logic          out_fire;
  logic [W-1:0]  total_d;
  logic [W-1:0]  msg_sel;

  assign in_ready  = (state_q == COLLECT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  // Running total: channel LLR seeds it, every check message is folded in with saturation
  always_comb begin
    total_d = (cnt_q == '0) ? in_data : sat_add(total_q, in_data);
  end

  // Select the check message being excluded from the current extrinsic output
  always_comb begin
    msg_sel = '0;
    for (int i = 0; i < DEG; i++) begin
      if (k_q == KW'(i)) msg_sel = msg_q[i];
    end
  end

  // Output word is built purely from registers, so it holds while the consumer stalls
  sat_subtractor #(
    .INT  (INT),
    .FRAC (FRAC)
  ) u_sub (
    .a (total_q),
    .b (msg_sel),
    .c (out_data)
  );

  // Check-message buffer; contents are overwritten each frame so it needs no reset
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int i = 0; i < DEG; i++) begin
        if (cnt_q == CW'(i + 1)) msg_q[i] <= in_data;
      end
    end
  end

  // Frame FSM: collect DEG+1 words, then emit DEG extrinsic words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      k_q         <= '0;
      total_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef VN_HARD_DECISION_EN
      out_hard    <= 1'b0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_fire) begin
            total_q <= total_d;
            if (cnt_q == CNT_LAST) begin
              state_q     <= EMIT;
              cnt_q       <= '0;
              k_q         <= '0;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
`ifdef VN_HARD_DECISION_EN
              out_hard    <= total_d[W-1];
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (out_last_q) begin
              state_q     <= COLLECT;
              cnt_q       <= '0;
              k_q         <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              k_q        <= k_q + 1'b1;
              out_last_q <= ((k_q + 1'b1) == K_LAST);
            end
          end
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

endmodule
